// File: rtl/gf_pkg.sv
// GF(2^8) arithmetic (primitive polynomial 0x11d), alpha power table and the
// syndrome vector type shared by the Reed-Solomon decoder stages.
package gf_pkg;

   localparam int SYMB_WIDTH  = 8;
   localparam int FIELD_ORDER = (1 << SYMB_WIDTH) - 1;
   localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11d;
   localparam int SYND_ROOTS  = 4;

   typedef logic [SYMB_WIDTH-1:0] symb_t;
   typedef symb_t alpha_to_symb_t;
   typedef symb_t synd_vec_t [SYND_ROOTS];

   // Shift-and-add multiply; each shift reduces by the primitive polynomial.
   function automatic symb_t gf_mult(input symb_t a, input symb_t b);
      symb_t p;
      symb_t x;
      p = '0;
      x = a;
      for (int i = 0; i < SYMB_WIDTH; i++) begin
         if (b[i]) p = p ^ x;
         x = x[SYMB_WIDTH-1] ? ((x << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0]) : (x << 1);
      end
      return p;
   endfunction

   function automatic alpha_to_symb_t alpha_to_symb(input int idx);
      alpha_to_symb_t x;
      x = symb_t'(1);
      for (int i = 0; i < idx; i++) x = gf_mult(x, symb_t'(2));
      return x;
   endfunction

   function automatic symb_t alpha_pow(input int e);
      int idx;
      idx = e % FIELD_ORDER;
      if (idx < 0) idx = idx + FIELD_ORDER;
      return alpha_to_symb(idx);
   endfunction

endpackage

// File: rtl/rs_synd_cell.sv
// One syndrome root: Horner accumulator acc = acc*alpha^EXP ^ symb, with the
// constant alpha power fixed at elaboration. acc_nxt is the post-update value.
module rs_synd_cell
   import gf_pkg::*;
#(
   parameter int EXP = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  load,
   input  logic                  en,
   input  logic [SYMB_WIDTH-1:0] symb,
   output logic [SYMB_WIDTH-1:0] acc_nxt
);

   localparam symb_t ALPHA_C = alpha_pow(EXP);

   symb_t acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (load)    acc_d = symb;
      else if (en) acc_d = gf_mult(acc_q, ALPHA_C) ^ symb;
   end

   assign acc_nxt = acc_d;

   // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) acc_q <= '0;
      else       acc_q <= acc_d;
   end

endmodule

// File: rtl/rs_syndrome.sv
// RS decoder front stage: ROOTS_NUM Horner syndromes, handed off over valid/ready.
// Define RS_SYND_LEN_CHK_EN to add the codeword length check (synd_len_err).
module rs_syndrome
   import gf_pkg::*;
#(
   parameter int ROOTS_NUM = SYND_ROOTS,
   parameter int FCR       = 1
`ifdef RS_SYND_LEN_CHK_EN
   , parameter int N_LEN   = 255
`endif
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [SYMB_WIDTH-1:0]           s_symb,
   input  logic                            s_sop,
   input  logic                            s_eop,
   output logic                            synd_valid,
   input  logic                            synd_ready,
   output logic [ROOTS_NUM*SYMB_WIDTH-1:0] synd,
   output logic                            synd_zero
`ifdef RS_SYND_LEN_CHK_EN
   , output logic                          synd_len_err
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_HOLD} state_t;

   state_t state_q, state_d;
   logic   accept, load, en, frame_end, all_zero;
   logic [SYMB_WIDTH-1:0]           acc_nxt [ROOTS_NUM];
   logic [ROOTS_NUM*SYMB_WIDTH-1:0] synd_q, synd_d;
   logic                            zero_q, zero_d;

   assign s_ready   = rstn && (state_q != ST_HOLD);
   assign accept    = s_valid && s_ready;
   // A sop beat (re)starts a frame in IDLE or ACCUM; non-sop beats in IDLE are dropped.
   assign load      = accept && s_sop;
   assign en        = accept && !s_sop && (state_q == ST_ACCUM);
   assign frame_end = accept && s_eop && (s_sop || (state_q == ST_ACCUM));

   for (genvar j = 0; j < ROOTS_NUM; j++) begin : g_cell
      rs_synd_cell #(.EXP(FCR + j)) u_cell (
         .clk     (clk),
         .rstn    (rstn),
         .load    (load),
         .en      (en),
         .symb    (s_symb),
         .acc_nxt (acc_nxt[j])
      );
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (load)       state_d = s_eop ? ST_HOLD : ST_ACCUM;
         ST_ACCUM: if (frame_end)  state_d = ST_HOLD;
         ST_HOLD:  if (synd_ready) state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      synd_d   = synd_q;
      zero_d   = zero_q;
      all_zero = 1'b1;
      for (int j = 0; j < ROOTS_NUM; j++) begin
         if (acc_nxt[j] != '0) all_zero = 1'b0;
      end
      if (frame_end) begin
         for (int j = 0; j < ROOTS_NUM; j++) synd_d[j*SYMB_WIDTH +: SYMB_WIDTH] = acc_nxt[j];
         zero_d = all_zero;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         synd_q  <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         synd_q  <= synd_d;
         zero_q  <= zero_d;
      end
   end

   assign synd_valid = (state_q == ST_HOLD);
   assign synd       = synd_q;
   assign synd_zero  = zero_q;

`ifdef RS_SYND_LEN_CHK_EN
   localparam int LEN_W = $clog2(N_LEN + 1);

   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             len_err_q, len_err_d;

   // Saturating count; the eop symbol itself is included in the compared count.
   always_comb begin
      cnt_d     = cnt_q;
      len_err_d = len_err_q;
      if (load)                    cnt_d = LEN_W'(1);
      else if (en && (cnt_q != '1)) cnt_d = cnt_q + LEN_W'(1);
      if (frame_end)               len_err_d = (cnt_d != LEN_W'(N_LEN));
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         len_err_q <= len_err_d;
      end
   end

   assign synd_len_err = len_err_q;
`endif

endmodule
